// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - round-robin arbiter and transaction sequencer sharing one spi_master
//
// Ports:
//   clk            system clock, all logic on posedge
//   rst            synchronous active-low reset
//   req            level request, one bit per requester
//   req_data       requester frames, requester i at [i*SEND_DATA_LEN +: SEND_DATA_LEN]
//   gnt            one-hot grant, held from START through DONE
//   done           one-cycle completion pulse to the grantee
//   err            one-cycle pulse with done when the master never went busy
//   rsp_data       last received word, updated on successful completion only
//   spi_en         master enable
//   spi_send_data  master transmit frame
//   spi_busy       master busy
//   spi_recv_data  master received word
module spi_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int SEND_DATA_LEN = 12,
    parameter int RECV_DATA_LEN = 8,
    parameter int EN_HOLD_CLKS  = 4,
    parameter int BUSY_TIMEOUT  = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ*SEND_DATA_LEN-1:0]   req_data,
    output logic [NUM_REQ-1:0]                 gnt,
    output logic [NUM_REQ-1:0]                 done,
    output logic                               err,
    output logic [RECV_DATA_LEN-1:0]           rsp_data,
    output logic                               spi_en,
    output logic [SEND_DATA_LEN-1:0]           spi_send_data,
    input  logic                               spi_busy,
    input  logic [RECV_DATA_LEN-1:0]           spi_recv_data
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HOLD_W = $clog2(EN_HOLD_CLKS + 1);
    localparam int TMR_W  = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        XFER      = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t               state, state_nxt;
    logic [PTR_W-1:0]     last, last_nxt;
    logic [HOLD_W-1:0]    hold_cnt, hold_cnt_nxt;
    logic [TMR_W-1:0]     timer, timer_nxt;
    logic                 err_flag, err_flag_nxt;

    logic [NUM_REQ-1:0]       gnt_nxt, done_nxt;
    logic                     err_nxt, spi_en_nxt;
    logic [RECV_DATA_LEN-1:0] rsp_data_nxt;
    logic [SEND_DATA_LEN-1:0] send_nxt;

    logic [PTR_W-1:0]         winner, cand;
    logic                     found;
    logic [SEND_DATA_LEN-1:0] win_frame;
    logic [NUM_REQ-1:0]       win_onehot;
    logic                     hold_end, timer_end;

    assign hold_end  = (hold_cnt == HOLD_W'(EN_HOLD_CLKS - 1));
    assign timer_end = (timer == TMR_W'(BUSY_TIMEOUT));

    // Search starts just after the last grantee and wraps, so the previous
    // winner is always considered last.
    always_comb begin
        int idx;
        idx    = 0;
        cand   = '0;
        winner = last;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx  = (int'(last) + k) % NUM_REQ;
            cand = PTR_W'(idx);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        win_frame  = '0;
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == PTR_W'(i)) begin
                win_frame     = req_data[i*SEND_DATA_LEN +: SEND_DATA_LEN];
                win_onehot[i] = 1'b1;
            end
        end
    end

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            last          <= PTR_W'(NUM_REQ - 1);
            hold_cnt      <= '0;
            timer         <= '0;
            err_flag      <= 1'b0;
            gnt           <= '0;
            done          <= '0;
            err           <= 1'b0;
            rsp_data      <= '0;
            spi_en        <= 1'b0;
            spi_send_data <= '0;
        end else begin
            state         <= state_nxt;
            last          <= last_nxt;
            hold_cnt      <= hold_cnt_nxt;
            timer         <= timer_nxt;
            err_flag      <= err_flag_nxt;
            gnt           <= gnt_nxt;
            done          <= done_nxt;
            err           <= err_nxt;
            rsp_data      <= rsp_data_nxt;
            spi_en        <= spi_en_nxt;
            spi_send_data <= send_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // A master left busy by an arbiter reset must finish first
                if (!spi_busy && (req != '0)) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (hold_end) begin
                    state_nxt = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (spi_busy) begin
                    state_nxt = XFER;
                end else if (timer_end) begin
                    state_nxt = DONE;
                end
            end
            XFER: begin
                if (!spi_busy) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for counters and registered outputs
    always_comb begin
        last_nxt     = last;
        hold_cnt_nxt = hold_cnt;
        timer_nxt    = timer;
        err_flag_nxt = err_flag;
        gnt_nxt      = gnt;
        done_nxt     = '0;
        err_nxt      = 1'b0;
        rsp_data_nxt = rsp_data;
        spi_en_nxt   = spi_en;
        send_nxt     = spi_send_data;
        case (state)
            IDLE: begin
                if (!spi_busy && (req != '0)) begin
                    last_nxt     = winner;
                    gnt_nxt      = win_onehot;
                    send_nxt     = win_frame;
                    spi_en_nxt   = 1'b1;
                    hold_cnt_nxt = '0;
                end
            end
            START: begin
                if (hold_end) begin
                    spi_en_nxt = 1'b0;
                    timer_nxt  = '0;
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            WAIT_BUSY: begin
                if (!spi_busy) begin
                    if (timer_end) begin
                        err_flag_nxt = 1'b1;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
            end
            XFER: begin
                if (!spi_busy) begin
                    rsp_data_nxt = spi_recv_data;
                end
            end
            DONE: begin
                gnt_nxt      = '0;
                err_flag_nxt = 1'b0;
            end
            default: ;
        endcase
        // The pulse registers load on entry so they are high during DONE itself
        if (state != DONE && state_nxt == DONE) begin
            done_nxt = gnt;
            err_nxt  = err_flag_nxt;
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - directed self-checking bench for spi_arbiter
module tb_spi_arbiter;

    localparam int NR = 4;
    localparam int SL = 12;
    localparam int RL = 8;
    localparam int EH = 4;
    localparam int BT = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req;
    logic [NR*SL-1:0] req_data;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    done;
    logic             err;
    logic [RL-1:0]    rsp_data;
    logic             spi_en;
    logic [SL-1:0]    spi_send_data;
    logic             spi_busy;
    logic [RL-1:0]    spi_recv_data;

    logic          model_on, manual, man_busy, mdl_busy, en_prev;
    logic [RL-1:0] model_rsp, mdl_recv;
    int            busy_len;
    int            en_run = 0;
    int            en_len = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    assign spi_busy      = manual ? man_busy : mdl_busy;
    assign spi_recv_data = mdl_recv;

    spi_arbiter #(
        .NUM_REQ(NR), .SEND_DATA_LEN(SL), .RECV_DATA_LEN(RL),
        .EN_HOLD_CLKS(EH), .BUSY_TIMEOUT(BT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt), .done(done), .err(err), .rsp_data(rsp_data),
        .spi_en(spi_en), .spi_send_data(spi_send_data),
        .spi_busy(spi_busy), .spi_recv_data(spi_recv_data)
    );

    always #5 clk = ~clk;

    // Length of the most recent completed spi_en high run
    always @(negedge clk) begin
        if (spi_en) begin
            en_run = en_run + 1;
        end else begin
            if (en_run != 0) en_len = en_run;
            en_run = 0;
        end
    end

    // Master model: goes busy 2 cycles after spi_en falls, stays busy busy_len cycles
    initial begin
        mdl_busy = 1'b0;
        mdl_recv = '0;
        en_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (model_on && en_prev && !spi_en) begin
                repeat (2) @(negedge clk);
                mdl_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                mdl_recv = model_rsp;
                mdl_busy = 1'b0;
                en_prev  = 1'b0;
            end else begin
                en_prev = spi_en;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_gnt();
        int c = 0;
        while (gnt == '0 && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (gnt == '0) check("gnt_wait", 32'(gnt != '0), 1);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done == '0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (done == '0) check("done_wait", 32'(done != '0), 1);
    endtask

    task automatic wait_busy();
        int c = 0;
        while (!spi_busy && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (!spi_busy) check("busy_wait", 32'(spi_busy), 1);
    endtask

    initial begin
        int cyc;
        int g;
        int exp_i;
        rst = 1'b0; req = '0; req_data = '0;
        model_on = 1'b1; manual = 1'b0; man_busy = 1'b0;
        model_rsp = '0; busy_len = 5;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_en", spi_en, 0);
        check("rst_send", spi_send_data, 0);
        check("rst_rsp", rsp_data, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single request
        req_data[0 +: SL] = 12'hA5C;
        model_rsp = 8'h3C;
        req = 4'b0001;
        @(negedge clk);
        check("single_gnt", gnt, 4'b0001);
        check("single_en", spi_en, 1);
        check("single_send", spi_send_data, 12'hA5C);
        wait_done(cyc);
        req = '0;
        check("single_done", done, 4'b0001);
        check("single_rsp", rsp_data, 8'h3C);
        check("single_err", err, 0);
        check("single_en_len", en_len, EH);

        // All requesting: order 0,1,2,3,0 from a fresh pointer
        rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
        req_data = {12'h444, 12'h333, 12'h222, 12'h111};
        model_rsp = 8'h5A;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_i = k % NR;
            wait_gnt();
            check("rr_gnt", gnt, 32'(1) << exp_i);
            check("rr_send", spi_send_data, 32'(12'h111) * (exp_i + 1));
            if (k == 4) req = '0;
            wait_done(cyc);
            check("rr_done", done, 32'(1) << exp_i);
            if (k < 4) begin
                g = 0;
                while (!spi_en && g < 10) begin
                    @(negedge clk);
                    g++;
                end
                check("rr_gap", g, 2);
            end
        end
        @(negedge clk);

        // Fairness after wrap: last grant 2, then 0 and 2 request together
        req = 4'b0100;
        wait_gnt();
        check("fair_pre", gnt, 4'b0100);
        req = '0;
        wait_done(cyc);
        @(negedge clk);
        req = 4'b0101;
        wait_gnt();
        check("fair_first", gnt, 4'b0001);
        wait_done(cyc);
        @(negedge clk);
        wait_gnt();
        check("fair_second", gnt, 4'b0100);
        req = '0;
        wait_done(cyc);
        check("fair_done", done, 4'b0100);
        @(negedge clk);

        // Start timeout: master never goes busy
        model_on = 1'b0;
        req = 4'b0001;
        wait_gnt();
        req = '0;
        wait_done(cyc);
        check("to_cycles", cyc + 1, EH + BT + 2);
        check("to_done", done, 4'b0001);
        check("to_err", err, 1);
        check("to_rsp", rsp_data, 8'h5A);
        @(negedge clk);
        check("to_idle_gnt", gnt, 0);
        check("to_idle_err", err, 0);
        check("to_idle_done", done, 0);

        // Reset during XFER with the master still busy
        model_on = 1'b1;
        busy_len = 20;
        model_rsp = 8'h77;
        req = 4'b0001;
        wait_gnt();
        req = '0;
        wait_busy();
        repeat (3) @(negedge clk);
        manual = 1'b1; man_busy = 1'b1; model_on = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_gnt", gnt, 0);
        check("mid_rst_en", spi_en, 0);
        check("mid_rst_send", spi_send_data, 0);
        check("mid_rst_rsp", rsp_data, 0);
        check("mid_rst_done", done, 0);
        rst = 1'b1;
        req = 4'b0010;
        repeat (4) @(negedge clk);
        check("busy_hold_gnt", gnt, 0);
        man_busy = 1'b0;
        @(negedge clk);
        check("busy_fall_gnt", gnt, 4'b0010);
        req = '0;
        wait_done(cyc);
        check("busy_fall_done", done, 4'b0010);
        check("busy_fall_err", err, 1);
        @(negedge clk);

        // Request dropped mid-transfer still completes
        manual = 1'b0;
        model_on = 1'b1;
        busy_len = 6;
        model_rsp = 8'hC3;
        req_data[0 +: SL] = 12'h123;
        req = 4'b0001;
        wait_gnt();
        check("drop_gnt", gnt, 4'b0001);
        check("drop_send", spi_send_data, 12'h123);
        wait_busy();
        req = '0;
        wait_done(cyc);
        check("drop_done", done, 4'b0001);
        check("drop_err", err, 0);
        check("drop_rsp", rsp_data, 8'hC3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
